ternary_mac_sched: RTL

Sequencing controller for the ternary matrix-vector datapath. It replaces the free-running count/state pair with a command-driven scheduler. The scheduler streams weight words into the weight loader, then runs a host-specified number of input vectors through the row-serial multiplier, one row per cycle. It sits between the pin-level input bus and the load/mult units, and owns every enable, index and row select they consume.

---
 rtl/ternary_mac_sched_if.sv | 20 ++
 rtl/ternary_mac_sched.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/ternary_mac_sched_if.sv
// Command and input-word handshake bundle for ternary_mac_sched.
// Host drives the master side; the scheduler is the slave.
interface ternary_mac_sched_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_count;
  logic       in_valid;
  logic       in_ready;

  modport master (
    output cmd_valid, cmd_op, cmd_count, in_valid,
    input  cmd_ready, in_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_count, in_valid,
    output cmd_ready, in_ready
  );
endinterface

// File: rtl/ternary_mac_sched.sv
// Command-driven load/mult scheduler for the ternary matrix-vector datapath.
// Define TERNARY_SCHED_ABORT_EN to allow ABORT to cancel a running LOAD/MULT.
module ternary_mac_sched #(
  parameter int MAX_IN_LEN  = 14,
  parameter int MAX_OUT_LEN = 7,
  parameter int LOAD_WORDS  = 14,
  parameter int MULT_LAT    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  ternary_mac_sched_if.slave bus,
  output logic               load_en,
  output logic [3:0]         load_idx,
  output logic               mult_en,
  output logic [2:0]         row,
  output logic               out_valid,
  output logic [2:0]         out_row,
  output logic               weights_valid,
  output logic               busy,
  output logic               done,
  output logic               err
);

  if (LOAD_WORDS * 16 < 2 * MAX_IN_LEN * MAX_OUT_LEN) begin : g_chk
    $error("LOAD_WORDS too small for weight matrix");
  end

  typedef enum logic [1:0] {IDLE, LOAD, MULT} state_t;

  localparam logic [3:0] WORD_LAST = 4'(LOAD_WORDS - 1);
  localparam logic [2:0] ROW_LAST  = 3'(MAX_OUT_LEN - 1);

  state_t     state;
  logic [3:0] word_cnt;
  logic [7:0] vec_left;
  logic       live;
  logic       cmd_fire;
  logic       op_load;
  logic       op_mult;
  logic       op_abort;
  logic       abort;
  logic       reject;

  assign op_load  = bus.cmd_op == 2'b01;
  assign op_mult  = bus.cmd_op == 2'b10;
  assign op_abort = bus.cmd_op == 2'b11;
  assign cmd_fire = bus.cmd_valid & bus.cmd_ready;

`ifdef TERNARY_SCHED_ABORT_EN
  assign bus.cmd_ready = live;
  assign abort  = cmd_fire & (state != IDLE) & op_abort;
  assign reject = cmd_fire & (state != IDLE) & (op_load | op_mult);
`else
  assign bus.cmd_ready = live & (state == IDLE);
  assign abort  = 1'b0;
  assign reject = 1'b0;
`endif

  assign bus.in_ready = (state == LOAD) |
                        ((state == MULT) & (row == 3'd0));
  assign load_en  = (state == LOAD) & bus.in_valid;
  assign load_idx = word_cnt;
  assign mult_en  = (state == MULT) &
                    ((row != 3'd0) | bus.in_valid);
  assign busy     = state != IDLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      word_cnt      <= '0;
      row           <= '0;
      vec_left      <= '0;
      weights_valid <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      live          <= 1'b0;
    end else begin
      live <= 1'b1;
      done <= 1'b0;
      err  <= reject;
      if (abort) begin
        state         <= IDLE;
        word_cnt      <= '0;
        row           <= '0;
        vec_left      <= '0;
        weights_valid <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (cmd_fire) begin
              unique case (1'b1)
                op_load: begin
                  state         <= LOAD;
                  word_cnt      <= '0;
                  weights_valid <= 1'b0;
                end
                op_mult: begin
                  if (weights_valid && bus.cmd_count != 8'd0) begin
                    state    <= MULT;
                    vec_left <= bus.cmd_count;
                    row      <= '0;
                  end else begin
                    err <= 1'b1;
                  end
                end
                default: ;
              endcase
            end
          end
          LOAD: begin
            if (bus.in_valid) begin
              word_cnt <= word_cnt + 4'd1;
              if (word_cnt == WORD_LAST) begin
                state         <= IDLE;
                word_cnt      <= '0;
                weights_valid <= 1'b1;
                done          <= 1'b1;
              end
            end
          end
          MULT: begin
            if (mult_en) begin
              if (row == ROW_LAST) begin
                row      <= '0;
                vec_left <= vec_left - 8'd1;
                if (vec_left == 8'd1) begin
                  state <= IDLE;
                  done  <= 1'b1;
                end
              end else begin
                row <= row + 3'd1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Result tag pipe mirrors datapath latency; abort flushes in-flight rows.
  logic       pv [MULT_LAT];
  logic [2:0] pr [MULT_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MULT_LAT; i++) begin
        pv[i] <= 1'b0;
        pr[i] <= '0;
      end
    end else begin
      pv[0] <= mult_en & ~abort;
      pr[0] <= row;
      for (int i = 1; i < MULT_LAT; i++) begin
        pv[i] <= pv[i-1] & ~abort;
        pr[i] <= pr[i-1];
      end
    end
  end

  assign out_valid = pv[MULT_LAT-1];
  assign out_row   = pr[MULT_LAT-1];

endmodule
